example_decimator: RTL and testbench



---
 rtl/example_decimator.sv | 71 +++++++
 tb/tb_example_decimator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/example_decimator.sv
// 3-stage CIC decimator: 16-bit signed in, one output per RATE accepted samples, unity DC gain.
// Output appears one cycle after the decimating sample; no backpressure, ce_in is always accepted.
module example_decimator #(
    parameter int DATA_W = 16,
    parameter int RATE   = 8,
    parameter int STAGES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_in,
    input  logic [DATA_W-1:0] sig_in,
    output logic              ce_out,
    output logic [DATA_W-1:0] sig_out
);

    localparam int CNT_W = $clog2(RATE);
    localparam int ACC_W = DATA_W + STAGES * CNT_W;

    logic [ACC_W-1:0] integ  [STAGES];
    logic [ACC_W-1:0] dly    [STAGES];
    logic [ACC_W-1:0] comb_v [STAGES];
    logic [ACC_W-1:0] sig_ext;
    logic [ACC_W-1:0] comb_acc;
    logic [CNT_W-1:0] phase;
    logic             dec_evt;
    logic             dump_pend;

    assign sig_ext = {{(ACC_W-DATA_W){sig_in[DATA_W-1]}}, sig_in};
    assign dec_evt = ce_in && (phase == CNT_W'(RATE - 1));

    // Comb chain is purely combinational from the delay registers; only sampled when dumping.
    always_comb begin
        comb_acc = integ[STAGES-1];
        for (int i = 0; i < STAGES; i++) begin
            comb_acc  = comb_acc - dly[i];
            comb_v[i] = comb_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                integ[i] <= '0;
                dly[i]   <= '0;
            end
            phase     <= '0;
            dump_pend <= 1'b0;
            ce_out    <= 1'b0;
            sig_out   <= '0;
        end else begin
            if (ce_in) begin
                integ[0] <= integ[0] + sig_ext;
                for (int i = 1; i < STAGES; i++) begin
                    integ[i] <= integ[i] + integ[i-1];
                end
                phase <= phase + CNT_W'(1);
            end
            dump_pend <= dec_evt;
            ce_out    <= dump_pend;
            // Modulo-2^ACC_W wrap in integrators cancels exactly through the combs.
            if (dump_pend) begin
                dly[0] <= integ[STAGES-1];
                for (int i = 1; i < STAGES; i++) begin
                    dly[i] <= comb_v[i-1];
                end
                sig_out <= comb_v[STAGES-1][ACC_W-1 -: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_example_decimator.sv
// Randomized scoreboard bench for example_decimator against an exact-integer CIC model.
module tb_example_decimator;

    localparam int RATE  = 8;
    localparam int SHIFT = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_in;
    logic [15:0] sig_in;
    logic        ce_out;
    logic [15:0] sig_out;

    example_decimator dut (
        .clk     (clk),
        .reset   (reset),
        .ce_in   (ce_in),
        .sig_in  (sig_in),
        .ce_out  (ce_out),
        .sig_out (sig_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          edge_no;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          edge_n   = 0;
    bit          last_rst = 1'b1;
    logic [15:0] held     = 16'h0;

    // Model: running sums of the accepted sample history, decimated, then a
    // binomial third difference of the decimated sequence, floor-divided by RATE^3.
    longint s0, s1, s2, v1, v2, v3;
    int     acc_n;

    function automatic void model_reset();
        s0 = 0; s1 = 0; s2 = 0;
        v1 = 0; v2 = 0; v3 = 0;
        acc_n = 0;
    endfunction

    function automatic void model_sample(input logic [15:0] x);
        longint xs;
        longint y;
        exp_t   e;
        xs = longint'($signed(x));
        s2 = s2 + s1;
        s1 = s1 + s0;
        s0 = s0 + xs;
        acc_n++;
        if (acc_n % RATE == 0) begin
            y  = s2 - 3 * v1 + 3 * v2 - v3;
            v3 = v2;
            v2 = v1;
            v1 = s2;
            e.val     = 16'(y >>> SHIFT);
            e.edge_no = edge_n + 1;
            sb.push_back(e);
        end
    endfunction

    task automatic step(input bit r, input bit c, input logic [15:0] x);
        reset  = r;
        ce_in  = c;
        sig_in = x;
        @(posedge clk);
        edge_n++;
        last_rst = r;
        if (r) begin
            model_reset();
            while (sb.size() > 0 && sb[$].edge_no >= edge_n) void'(sb.pop_back());
        end else if (c) begin
            model_sample(x);
        end
        #1;
    endtask

    task automatic check_val(input string name, input logic [15:0] exp_v);
        checks++;
        if (sig_out !== exp_v) begin
            failures++;
            $display("FAIL %s sig_out=%0d required=%0d", name, $signed(sig_out), $signed(exp_v));
        end
    endtask

    always @(negedge clk) begin
        if (last_rst) begin
            checks++;
            if (sig_out !== 16'h0 || ce_out !== 1'b0) begin
                failures++;
                $display("FAIL reset_state sig_out=%0d ce_out=%0b required 0/0", $signed(sig_out), ce_out);
            end
            held = 16'h0;
        end else if (ce_out === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ce_out edge=%0d sig_out=%0d required no pulse", edge_n, $signed(sig_out));
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.edge_no != edge_n || sig_out !== mon_e.val) begin
                    failures++;
                    $display("FAIL output edge=%0d sig_out=%0d required edge=%0d sig_out=%0d",
                             edge_n, $signed(sig_out), mon_e.edge_no, $signed(mon_e.val));
                end
            end
            held = sig_out;
        end else begin
            checks++;
            if (sig_out !== held) begin
                failures++;
                $display("FAIL hold edge=%0d sig_out=%0d required=%0d", edge_n, $signed(sig_out), $signed(held));
            end
            if (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
                checks++;
                failures++;
                mon_e = sb.pop_front();
                $display("FAIL missing_ce_out edge=%0d ce_out=0 required pulse at edge=%0d value=%0d",
                         edge_n, mon_e.edge_no, $signed(mon_e.val));
            end
        end
    end

    initial begin
        logic [15:0] x;
        bit          r;
        bit          c;
        int          pick;
        model_reset();

        repeat (3) step(1'b1, 1'b1, 16'd1234);

        repeat (80) step(1'b0, 1'b1, 16'd1000);
        check_val("dc_pos", 16'd1000);

        step(1'b1, 1'b0, 16'd0);
        repeat (80) step(1'b0, 1'b1, 16'd32767);
        check_val("full_scale_pos", 16'd32767);

        step(1'b1, 1'b0, 16'd0);
        repeat (80) step(1'b0, 1'b1, 16'h8000);
        check_val("full_scale_neg", 16'h8000);

        step(1'b1, 1'b0, 16'd0);
        for (int i = 0; i < 200; i++) step(1'b0, (i % 2) == 0, 16'(-500));
        check_val("gated_neg", 16'(-500));

        step(1'b1, 1'b0, 16'd0);
        x = 16'd32600;
        repeat (400) begin
            step(1'b0, 1'b1, x);
            x = x + 16'd1;
        end
        x = 16'hFF00;
        repeat (400) begin
            step(1'b0, 1'b1, x);
            x = x + 16'd1;
        end

        step(1'b1, 1'b0, 16'd0);
        repeat (29) step(1'b0, 1'b1, 16'd700);
        step(1'b1, 1'b1, 16'd700);
        check_val("mid_reset_clear", 16'd0);
        repeat (40) step(1'b0, 1'b1, 16'd700);

        repeat (3000) begin
            r    = ($urandom_range(0, 299) == 0);
            c    = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 9);
            if (pick == 0)      x = 16'h7FFF;
            else if (pick == 1) x = 16'h8000;
            else                x = 16'($urandom);
            step(r, c, x);
        end

        repeat (12) step(1'b0, 1'b0, 16'd0);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
